mc_control_fsm: RTL and testbench
=================================

MC_CONTROL_FSM -- requirements
Module: mc_control_fsm

Interface
REQ-001 The block SHALL have parameter STATE_W, default 4, giving the width of the state output.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 rst  input  1  reset, synchronous, active-low.
REQ-004 opcode  input  6  instruction opcode field from the instruction register.
REQ-005 zero  input  1  ALU zero flag.
REQ-006 mem_ready  input  1  memory completion strobe; the access completes in any cycle where it is 1.
REQ-007 PCwe  output  1  program counter write enable.
REQ-008 IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA  output  1 each  standard multicycle datapath controls.
REQ-009 ALUSrcB, ALUOp, PCSource  output  2 each  datapath mux and ALU selects.
REQ-010 state  output  STATE_W  current state encoding.
REQ-011 illegal  output  1  sticky illegal-opcode flag.

Function
REQ-012 The state encodings SHALL be IF=0, ID=1, MADDR=2, MRD=3, MWB=4, MWR=5, REX=6, RWB=7, BR=8, JMP=9, IEX=10, IWB=11; encodings 12-15 SHALL go to IF on the next edge.
REQ-013 Transitions SHALL be as follows.
- IF->ID when mem_ready=1; otherwise hold IF.
- ID->MADDR for lw (0x23) and sw (0x2B).
- ID->REX for R-type (0x00).
- ID->BR for beq (0x04).
- ID->JMP for j (0x02).
- ID->IEX for addi (0x08).
- ID->IF for any other opcode, setting illegal.
REQ-014 From MADDR, the block SHALL go to MRD for lw and to MWR for sw.
REQ-015 MRD SHALL go to MWB when mem_ready=1 and hold otherwise; MWR SHALL go to IF when mem_ready=1 and hold otherwise.
REQ-016 MWB, RWB, IWB, BR and JMP SHALL each go to IF; REX SHALL go to RWB; IEX SHALL go to IWB.
REQ-017 Outputs SHALL be Moore-decoded from state, except PCwe and IRWrite, which also depend on mem_ready, zero and opcode. Every output not listed for a state is 0.
- IF: MemRead=1, ALUSrcB=01; IRWrite and PCwe equal mem_ready.
- ID: ALUSrcB=11.
- MADDR and IEX: ALUSrcA=1, ALUSrcB=10.
- MRD: MemRead=1, IorD=1.
- MWR: MemWrite=1, IorD=1.
- MWB: RegWrite=1, MemtoReg=1.
- REX: ALUSrcA=1, ALUOp=10.
- RWB: RegWrite=1, RegDst=1.
- IWB: RegWrite=1.
- BR: ALUSrcA=1, ALUOp=01, PCSource=01, PCwe=zero.
- JMP: PCSource=10, PCwe=1.
REQ-018 PCwe SHALL be 1 for exactly one cycle per instruction at most in IF and at most once more in BR/JMP; PCwe and MemWrite SHALL never be asserted in the same cycle.
REQ-019 The opcode SHALL be sampled in ID, MADDR and BR only; opcode changes in other states SHALL have no effect.
REQ-020 Once set, illegal SHALL stay 1 until reset; execution SHALL continue with the next fetch.

Reset
REQ-021 When rst=0 at a rising clk edge, the block SHALL enter IF and clear illegal, regardless of current state, including mid-wait in MRD/MWR.
REQ-022 During and immediately after reset, the outputs SHALL be the IF decode: MemRead=1, ALUSrcB=01, IRWrite=PCwe=mem_ready, all other outputs 0, state=0.

Configuration
REQ-023 With macro MC_CONTROL_BNE_EN defined, opcode 0x05 (bne) SHALL go ID->BR, and in BR PCwe SHALL equal ~zero for bne and zero for beq.
REQ-024 Without MC_CONTROL_BNE_EN, opcode 0x05 SHALL be treated as illegal (ID->IF, illegal=1).

Verification
REQ-025 Reset, then lw (0x23) with mem_ready=1 every cycle -> states 0,1,2,3,4,0; PCwe=1 only in the first IF cycle; RegWrite=1 only in state 4.
REQ-026 sw (0x2B) with mem_ready held 0 for 3 cycles in MWR -> state 5 held 4 cycles; MemWrite=1 throughout; then state 0.
REQ-027 beq with zero=1, then beq with zero=0 -> PCwe=1 in BR with PCSource=01 for the first, PCwe=0 in BR for the second.
REQ-028 Opcode 0x3F -> ID->IF; illegal=1 and remains 1 across a following R-type sequence 0,1,6,7,0.
REQ-029 rst=0 asserted while the FSM is in MRD waiting -> state=0 on the next edge; illegal=0; no RegWrite pulse.
REQ-030 With MC_CONTROL_BNE_EN defined, bne (0x05) with zero=0 -> PCwe=1 in BR; without the macro -> illegal=1 and BR is never entered.

Source files
------------

// File: rtl/mc_control_fsm.sv
// rtl/mc_control_fsm.sv - multicycle datapath control FSM; optional bne support via MC_CONTROL_BNE_EN
module mc_control_fsm #(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [5:0]         opcode,
    input  logic               zero,
    input  logic               mem_ready,
    output logic               PCwe,
    output logic               IorD,
    output logic               MemRead,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic               RegDst,
    output logic               MemtoReg,
    output logic               RegWrite,
    output logic               ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic [1:0]         ALUOp,
    output logic [1:0]         PCSource,
    output logic [STATE_W-1:0] state,
    output logic               illegal
);

    localparam logic [3:0] S_IF    = 4'd0;
    localparam logic [3:0] S_ID    = 4'd1;
    localparam logic [3:0] S_MADDR = 4'd2;
    localparam logic [3:0] S_MRD   = 4'd3;
    localparam logic [3:0] S_MWB   = 4'd4;
    localparam logic [3:0] S_MWR   = 4'd5;
    localparam logic [3:0] S_REX   = 4'd6;
    localparam logic [3:0] S_RWB   = 4'd7;
    localparam logic [3:0] S_BR    = 4'd8;
    localparam logic [3:0] S_JMP   = 4'd9;
    localparam logic [3:0] S_IEX   = 4'd10;
    localparam logic [3:0] S_IWB   = 4'd11;

    localparam logic [5:0] OP_R    = 6'h00;
    localparam logic [5:0] OP_J    = 6'h02;
    localparam logic [5:0] OP_BEQ  = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08;
    localparam logic [5:0] OP_LW   = 6'h23;
    localparam logic [5:0] OP_SW   = 6'h2B;

    logic [3:0] state_q, state_d;
    logic       illegal_q, illegal_d;
    logic [3:0] cur;
    logic       is_bne;

`ifdef MC_CONTROL_BNE_EN
    assign is_bne = (opcode == 6'h05);
`else
    assign is_bne = 1'b0;
`endif

    always_comb begin
        state_d   = S_IF;
        illegal_d = illegal_q;
        case (state_q)
            S_IF:    state_d = mem_ready ? S_ID : S_IF;
            S_ID: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MADDR;
                    OP_R:         state_d = S_REX;
                    OP_BEQ:       state_d = S_BR;
                    OP_J:         state_d = S_JMP;
                    OP_ADDI:      state_d = S_IEX;
                    default: begin
                        if (is_bne) begin
                            state_d = S_BR;
                        end else begin
                            state_d   = S_IF;
                            illegal_d = 1'b1;
                        end
                    end
                endcase
            end
            // An opcode that changed away from lw/sw mid-instruction abandons it
            S_MADDR: begin
                if (opcode == OP_LW)      state_d = S_MRD;
                else if (opcode == OP_SW) state_d = S_MWR;
                else                      state_d = S_IF;
            end
            S_MRD:   state_d = mem_ready ? S_MWB : S_MRD;
            S_MWR:   state_d = mem_ready ? S_IF : S_MWR;
            S_REX:   state_d = S_RWB;
            S_IEX:   state_d = S_IWB;
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IF;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    // While reset is held the outputs already show the fetch decode
    assign cur     = rst ? state_q : S_IF;
    assign state   = STATE_W'(cur);
    assign illegal = illegal_q & rst;

    always_comb begin
        PCwe     = 1'b0;
        IorD     = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        ALUOp    = 2'b00;
        PCSource = 2'b00;
        case (cur)
            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCwe    = mem_ready;
            end
            S_ID:    ALUSrcB = 2'b11;
            S_MADDR, S_IEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            S_MRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_MWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            S_REX: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            S_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            S_IWB:   RegWrite = 1'b1;
            S_BR: begin
                ALUSrcA  = 1'b1;
                ALUOp    = 2'b01;
                PCSource = 2'b01;
                PCwe     = is_bne ? ~zero : zero;
            end
            S_JMP: begin
                PCSource = 2'b10;
                PCwe     = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_mc_control_fsm.sv
// tb/tb_mc_control_fsm.sv - table-driven scoreboard bench for mc_control_fsm
module tb_mc_control_fsm;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       PCwe, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
    logic [1:0] ALUSrcB, ALUOp, PCSource;
    logic [3:0] state;
    logic       illegal;

    mc_control_fsm #(.STATE_W(4)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .PCwe(PCwe), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite),
        .IRWrite(IRWrite), .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
        .state(state), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic [5:0] opc;
        logic       z;
        logic       mr;
        logic [3:0] st;
        logic       pcwe;
        logic       irw;
        logic       mrd;
        logic       mwr;
        logic       rw;
        logic       ill;
        logic [1:0] pcs;
        logic [1:0] srcb;
    } vec_t;

    typedef struct packed {
        logic [3:0] st;
        logic       pcwe;
        logic       irw;
        logic       mrd;
        logic       mwr;
        logic       rw;
        logic       ill;
        logic [1:0] pcs;
        logic [1:0] srcb;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic add(input logic r, input logic [5:0] o, input logic z, input logic mr,
                       input logic [3:0] st, input logic pcwe, input logic irw, input logic mrd,
                       input logic mwr, input logic rw, input logic ill,
                       input logic [1:0] pcs, input logic [1:0] srcb);
        vec_t v;
        v = '{rst: r, opc: o, z: z, mr: mr, st: st, pcwe: pcwe, irw: irw, mrd: mrd,
              mwr: mwr, rw: rw, ill: ill, pcs: pcs, srcb: srcb};
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input int step, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d actual=%0h required=%0h", name, step, act, req);
        end
    endtask

    initial begin
        exp_t e;
        // reset held, then released into a fetch
        //  rst opc    z  mr  st pcwe irw mrd mwr rw ill pcs srcb
        add(0, 6'h00, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 1);
        add(0, 6'h00, 0, 1,  0, 1, 1, 1, 0, 0, 0, 0, 1);
        // lw with mem_ready always high: 0,1,2,3,4,0
        add(1, 6'h23, 0, 1,  0, 1, 1, 1, 0, 0, 0, 0, 1);
        add(1, 6'h23, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 3);
        add(1, 6'h23, 0, 1,  2, 0, 0, 0, 0, 0, 0, 0, 2);
        add(1, 6'h23, 0, 1,  3, 0, 0, 1, 0, 0, 0, 0, 0);
        add(1, 6'h23, 0, 1,  4, 0, 0, 0, 0, 1, 0, 0, 0);
        add(1, 6'h23, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 1);
        // sw with three wait cycles in MWR
        add(1, 6'h2B, 0, 1,  0, 1, 1, 1, 0, 0, 0, 0, 1);
        add(1, 6'h2B, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 3);
        add(1, 6'h2B, 0, 1,  2, 0, 0, 0, 0, 0, 0, 0, 2);
        add(1, 6'h2B, 0, 0,  5, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 6'h2B, 0, 0,  5, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 6'h2B, 0, 0,  5, 0, 0, 0, 1, 0, 0, 0, 0);
        add(1, 6'h2B, 0, 1,  5, 0, 0, 0, 1, 0, 0, 0, 0);
        // beq taken, then beq not taken
        add(1, 6'h04, 0, 1,  0, 1, 1, 1, 0, 0, 0, 0, 1);
        add(1, 6'h04, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 3);
        add(1, 6'h04, 1, 1,  8, 1, 0, 0, 0, 0, 0, 1, 0);
        add(1, 6'h04, 0, 1,  0, 1, 1, 1, 0, 0, 0, 0, 1);
        add(1, 6'h04, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 3);
        add(1, 6'h04, 0, 1,  8, 0, 0, 0, 0, 0, 0, 1, 0);
        // illegal opcode, then an R-type whose opcode wobbles in REX/RWB
        add(1, 6'h3F, 0, 1,  0, 1, 1, 1, 0, 0, 0, 0, 1);
        add(1, 6'h3F, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 3);
        add(1, 6'h00, 0, 1,  0, 1, 1, 1, 0, 0, 1, 0, 1);
        add(1, 6'h00, 0, 1,  1, 0, 0, 0, 0, 0, 1, 0, 3);
        add(1, 6'h23, 0, 1,  6, 0, 0, 0, 0, 0, 1, 0, 0);
        add(1, 6'h2B, 0, 1,  7, 0, 0, 0, 0, 1, 1, 0, 0);
        add(1, 6'h00, 0, 0,  0, 0, 0, 1, 0, 0, 1, 0, 1);
        // reset while waiting in MRD
        add(1, 6'h23, 0, 1,  0, 1, 1, 1, 0, 0, 1, 0, 1);
        add(1, 6'h23, 0, 1,  1, 0, 0, 0, 0, 0, 1, 0, 3);
        add(1, 6'h23, 0, 0,  2, 0, 0, 0, 0, 0, 1, 0, 2);
        add(1, 6'h23, 0, 0,  3, 0, 0, 1, 0, 0, 1, 0, 0);
        add(0, 6'h23, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 1);
        add(1, 6'h23, 0, 0,  0, 0, 0, 1, 0, 0, 0, 0, 1);
        // bne with zero=0
        add(1, 6'h05, 0, 1,  0, 1, 1, 1, 0, 0, 0, 0, 1);
        add(1, 6'h05, 0, 1,  1, 0, 0, 0, 0, 0, 0, 0, 3);
`ifdef MC_CONTROL_BNE_EN
        add(1, 6'h05, 0, 0,  8, 1, 0, 0, 0, 0, 0, 1, 0);
        add(1, 6'h05, 1, 0,  0, 0, 0, 1, 0, 0, 0, 0, 1);
`else
        add(1, 6'h05, 0, 0,  0, 0, 0, 1, 0, 0, 1, 0, 1);
        add(1, 6'h05, 0, 0,  0, 0, 0, 1, 0, 0, 1, 0, 1);
`endif

        rst = 1'b0; opcode = '0; zero = 1'b0; mem_ready = 1'b0;
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; opcode = vecs[i].opc; zero = vecs[i].z; mem_ready = vecs[i].mr;
            sb.push_back('{st: vecs[i].st, pcwe: vecs[i].pcwe, irw: vecs[i].irw, mrd: vecs[i].mrd,
                           mwr: vecs[i].mwr, rw: vecs[i].rw, ill: vecs[i].ill,
                           pcs: vecs[i].pcs, srcb: vecs[i].srcb});
            #1;
            e = sb.pop_front();
            check("state",    i, state,             e.st);
            check("PCwe",     i, {3'b0, PCwe},      {3'b0, e.pcwe});
            check("IRWrite",  i, {3'b0, IRWrite},   {3'b0, e.irw});
            check("MemRead",  i, {3'b0, MemRead},   {3'b0, e.mrd});
            check("MemWrite", i, {3'b0, MemWrite},  {3'b0, e.mwr});
            check("RegWrite", i, {3'b0, RegWrite},  {3'b0, e.rw});
            check("illegal",  i, {3'b0, illegal},   {3'b0, e.ill});
            check("PCSource", i, {2'b0, PCSource},  {2'b0, e.pcs});
            check("ALUSrcB",  i, {2'b0, ALUSrcB},   {2'b0, e.srcb});
            check("pcwe_and_memwrite", i, {3'b0, PCwe & MemWrite}, 4'h0);
        end
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
